bc_control_sequencer: RTL

- Control unit for the 16-bit basic computer; the issuing end of the ALU/register-file interface.
- Runs the fetch/indirect/execute timing sequence from the IR contents and status flags.
- Drives the ALU operation select and register load/increment/clear strobes, bus select and memory strobes.
- Consumes ALU flags and AC/DR/E status on the way back.

---
 rtl/bc_control_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bc_control_sequencer.sv
// Control sequencer for the 16-bit basic computer.
// Holds the timing counter SC and the HALTED flag; every other output is a
// combinational decode of SC, IR, the returned status flags and HALTED.
module bc_control_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IR,
    input  logic             AC_MSB,
    input  logic             AC_Z,
    input  logic             DR_Z,
    input  logic             E,
    output logic [2:0]       SC,
    output logic             HALTED,
    output logic [2:0]       BUS_SEL,
    output logic             LD_AR,
    output logic             INC_AR,
    output logic             LD_PC,
    output logic             INC_PC,
    output logic             LD_DR,
    output logic             INC_DR,
    output logic             LD_AC,
    output logic             INC_AC,
    output logic             CLR_AC,
    output logic             LD_IR,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic [2:0]       OPSEL,
    output logic             E_LD,
    output logic             CLR_E,
    output logic             CMP_E
);

    // Timing states
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;

    // Memory-reference opcodes
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;

    // Bus sources
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // ALU selects
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_DR  = 3'b010;
    localparam logic [2:0] ALU_CMA = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_NOP = 3'b111;

    logic [2:0] sc_r;
    logic       halted_r;
    logic [2:0] sc_nxt_s;
    logic       halt_nxt_s;
    logic [2:0] opcode_s;
    logic       i_bit_s;
    logic       mem_ref_s;

    assign opcode_s  = IR[14:12];
    assign i_bit_s   = IR[WIDTH-1];
    assign mem_ref_s = (opcode_s != 3'd7);
    assign SC        = sc_r;
    assign HALTED    = halted_r;

    // Decode the current timing step into strobes and the next SC/HALTED value
    always_comb begin
        sc_nxt_s   = sc_r + 3'd1;
        halt_nxt_s = halted_r;
        BUS_SEL    = BUS_NONE;
        LD_AR      = 1'b0;
        INC_AR     = 1'b0;
        LD_PC      = 1'b0;
        INC_PC     = 1'b0;
        LD_DR      = 1'b0;
        INC_DR     = 1'b0;
        LD_AC      = 1'b0;
        INC_AC     = 1'b0;
        CLR_AC     = 1'b0;
        LD_IR      = 1'b0;
        MEM_RD     = 1'b0;
        MEM_WR     = 1'b0;
        OPSEL      = ALU_NOP;
        E_LD       = 1'b0;
        CLR_E      = 1'b0;
        CMP_E      = 1'b0;
        if (!rst_n) begin
            sc_nxt_s = T0;
        end else if (halted_r) begin
            // Frozen until reset; outputs stay at their defaults
            sc_nxt_s = sc_r;
        end else begin
            case (sc_r)
                T0: begin
                    BUS_SEL = BUS_PC;
                    LD_AR   = 1'b1;
                end
                T1: begin
                    BUS_SEL = BUS_MEM;
                    MEM_RD  = 1'b1;
                    LD_IR   = 1'b1;
                    INC_PC  = 1'b1;
                end
                T2: begin
                    BUS_SEL = BUS_IR;
                    LD_AR   = 1'b1;
                end
                T3: begin
                    if (mem_ref_s) begin
                        if (i_bit_s) begin
                            // Indirect: replace AR with the pointer word
                            BUS_SEL = BUS_MEM;
                            MEM_RD  = 1'b1;
                            LD_AR   = 1'b1;
                        end else begin
                            BUS_SEL = BUS_NONE;
                        end
                    end else begin
                        sc_nxt_s = T0;
                        if (!i_bit_s) begin
                            // Register reference: only the highest set bit acts
                            casez (IR[11:0])
                                12'b1???_????_????: CLR_AC = 1'b1;
                                12'b01??_????_????: CLR_E  = 1'b1;
                                12'b001?_????_????: begin
                                    OPSEL = ALU_CMA;
                                    LD_AC = 1'b1;
                                end
                                12'b0001_????_????: CMP_E = 1'b1;
                                12'b0000_1???_????: begin
                                    OPSEL = ALU_SHR;
                                    LD_AC = 1'b1;
                                    E_LD  = 1'b1;
                                end
                                12'b0000_01??_????: begin
                                    OPSEL = ALU_SHL;
                                    LD_AC = 1'b1;
                                    E_LD  = 1'b1;
                                end
                                12'b0000_001?_????: INC_AC = 1'b1;
                                12'b0000_0001_????: INC_PC = ~AC_MSB;
                                12'b0000_0000_1???: INC_PC = AC_MSB;
                                12'b0000_0000_01??: INC_PC = AC_Z;
                                12'b0000_0000_001?: INC_PC = ~E;
                                12'b0000_0000_0001: begin
                                    // HLT keeps SC at T3 while stopped
                                    halt_nxt_s = 1'b1;
                                    sc_nxt_s   = sc_r;
                                end
                                default: INC_PC = 1'b0;
                            endcase
                        end else begin
                            // I/O group is a no-op here
                            BUS_SEL = BUS_NONE;
                        end
                    end
                end
                T4: begin
                    case (opcode_s)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            BUS_SEL = BUS_MEM;
                            MEM_RD  = 1'b1;
                            LD_DR   = 1'b1;
                        end
                        OP_STA: begin
                            BUS_SEL  = BUS_AC;
                            MEM_WR   = 1'b1;
                            sc_nxt_s = T0;
                        end
                        OP_BUN: begin
                            BUS_SEL  = BUS_AR;
                            LD_PC    = 1'b1;
                            sc_nxt_s = T0;
                        end
                        OP_BSA: begin
                            BUS_SEL = BUS_PC;
                            MEM_WR  = 1'b1;
                            INC_AR  = 1'b1;
                        end
                        default: sc_nxt_s = T0;
                    endcase
                end
                T5: begin
                    sc_nxt_s = T0;
                    case (opcode_s)
                        OP_AND: begin
                            OPSEL = ALU_AND;
                            LD_AC = 1'b1;
                        end
                        OP_ADD: begin
                            OPSEL = ALU_ADD;
                            LD_AC = 1'b1;
                            E_LD  = 1'b1;
                        end
                        OP_LDA: begin
                            OPSEL = ALU_DR;
                            LD_AC = 1'b1;
                        end
                        OP_BSA: begin
                            BUS_SEL = BUS_AR;
                            LD_PC   = 1'b1;
                        end
                        OP_ISZ: begin
                            INC_DR   = 1'b1;
                            sc_nxt_s = T6;
                        end
                        default: sc_nxt_s = T0;
                    endcase
                end
                T6: begin
                    sc_nxt_s = T0;
                    if (opcode_s == OP_ISZ) begin
                        BUS_SEL = BUS_DR;
                        MEM_WR  = 1'b1;
                        INC_PC  = DR_Z;
                    end else begin
                        BUS_SEL = BUS_NONE;
                    end
                end
                default: sc_nxt_s = T0;
            endcase
        end
    end

    // Timing counter and halt flag, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_r     <= T0;
            halted_r <= 1'b0;
        end else begin
            sc_r     <= sc_nxt_s;
            halted_r <= halt_nxt_s;
        end
    end

endmodule
